// File: rtl/key_move_pkg.sv
// key_move_pkg: PS/2 scancodes, one-hot directions, resolutions and scan FSM states.
package key_move_pkg;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_RIGHT = 8'h23;
  localparam logic [7:0] SC_LEFT = 8'h1C;
  localparam logic [7:0] SC_DOWN = 8'h1B;
  localparam logic [7:0] SC_UP = 8'h1D;
  localparam logic [7:0] SC_X_RIGHT = 8'h74;
  localparam logic [7:0] SC_X_LEFT = 8'h6B;
  localparam logic [7:0] SC_X_DOWN = 8'h72;
  localparam logic [7:0] SC_X_UP = 8'h75;
  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT = 4'b0010;
  localparam logic [3:0] DIR_DOWN = 4'b0100;
  localparam logic [3:0] DIR_UP = 4'b1000;
  localparam logic [11:0] H_RES_0 = 12'd640;
  localparam logic [11:0] V_RES_0 = 12'd480;
  localparam logic [11:0] H_RES_1 = 12'd800;
  localparam logic [11:0] V_RES_1 = 12'd600;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} scan_state_t;
  function automatic logic [3:0] key_dir(input logic [7:0] key, input logic ext);
    return ext ? (key == SC_X_RIGHT ? DIR_RIGHT : key == SC_X_LEFT ? DIR_LEFT :
                  key == SC_X_DOWN ? DIR_DOWN : key == SC_X_UP ? DIR_UP : DIR_NONE)
               : (key == SC_RIGHT ? DIR_RIGHT : key == SC_LEFT ? DIR_LEFT :
                  key == SC_DOWN ? DIR_DOWN : key == SC_UP ? DIR_UP : DIR_NONE);
  endfunction
endpackage

// File: rtl/ps2_scan_fsm.sv
// ps2_scan_fsm: make/break/extended scancode decoder owning the held-direction register.
module ps2_scan_fsm
  import key_move_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       new_code,
  output logic [3:0] dir
);
  scan_state_t state, state_nx;
  logic [3:0] dir_nx, code_dir;
  logic brk;
  assign brk = state == BRK || state == EXT_BRK;
  assign code_dir = key_dir(key, state == EXT || state == EXT_BRK);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      dir <= DIR_NONE;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
    end
  // A break only releases the key that is currently held; prefixes decode to DIR_NONE.
  always_comb begin
    state_nx = state;
    dir_nx = dir;
    if (new_code) begin
      state_nx = brk ? IDLE : key == SC_BRK ? (state == EXT ? EXT_BRK : BRK) :
                 key == SC_EXT ? EXT : IDLE;
      dir_nx = brk ? (code_dir == dir ? DIR_NONE : dir) :
               code_dir != DIR_NONE ? code_dir : dir;
    end
  end
endmodule

// File: rtl/key_move_ctrl.sv
// key_move_ctrl: keyboard direction, movement prescaler and wrapping block position.
// Define KEY_MOVE_FRAME_SYNC_EN to defer moves until the next frame_start.
module key_move_ctrl
  import key_move_pkg::*;
#(
  parameter int TICK_DIV = 131072,
  parameter int STEP = 1,
  parameter int BLK_W = 50,
  parameter int BLK_H = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [7:0]  key,
  input  logic        new_code,
  input  logic        frame_start,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic [3:0]  dir,
  output logic        tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  logic [11:0] h_res, v_res, x_max, y_max;
  logic upd;
  function automatic logic [10:0] axis_next(input logic [10:0] p, input logic [11:0] lim,
                                            input logic inc, input logic dec);
    logic [11:0] q, s;
    q = {1'b0, p};
    s = 12'(STEP);
    return q > lim ? 11'(lim) :
           inc ? (q + s > lim ? 11'd0 : 11'(q + s)) :
           dec ? (q < s ? 11'(lim) : 11'(q - s)) : p;
  endfunction
  ps2_scan_fsm u_scan (
    .clk(clk),
    .rst(rst),
    .key(key),
    .new_code(new_code),
    .dir(dir)
  );
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign x_max = h_res - 12'(BLK_W);
  assign y_max = v_res - 12'(BLK_H);
`ifdef KEY_MOVE_FRAME_SYNC_EN
  logic pend;
  assign upd = (pend | tick) & frame_start;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= 1'b0;
    else pend <= !upd && (pend || tick);
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign upd = tick;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      h_res <= H_RES_0;
      v_res <= V_RES_0;
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      h_res <= mode ? H_RES_1 : H_RES_0;
      v_res <= mode ? V_RES_1 : V_RES_0;
      pos_x <= axis_next(pos_x, x_max, upd & dir[0], upd & dir[1]);
      pos_y <= axis_next(pos_y, y_max, upd & dir[2], upd & dir[3]);
    end
endmodule

// File: tb/tb_key_move_ctrl.sv
// tb_key_move_ctrl: directed and random key/mode stimulus against a behavioural position model.
module tb_key_move_ctrl;
  localparam int TD = 4;
  localparam int STEP = 1;
  logic clk = 0, rst = 1, mode = 0, new_code = 0, frame_start = 0;
  logic [7:0] key = 0;
  logic [10:0] pos_x, pos_y;
  logic [3:0] dir;
  logic tick;
  int tests = 0, fails = 0;
  int mx, my, mdir, mcnt;
  bit mext, mbrk, mmode, mpend, mupd;
  logic [7:0] codes [10] = '{8'hE0, 8'hF0, 8'h23, 8'h1C, 8'h1B, 8'h1D, 8'h74, 8'h6B, 8'h72, 8'h75};

  key_move_ctrl #(.TICK_DIV(TD), .STEP(STEP), .BLK_W(50), .BLK_H(50)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key(key), .new_code(new_code),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_dir(input logic [7:0] k, input bit ext);
    case ({ext, k})
      {1'b0, 8'h23}, {1'b1, 8'h74}: return 1;
      {1'b0, 8'h1C}, {1'b1, 8'h6B}: return 2;
      {1'b0, 8'h1B}, {1'b1, 8'h72}: return 4;
      {1'b0, 8'h1D}, {1'b1, 8'h75}: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int wrap_step(input int p, input int lim, input int d);
    if (p > lim) return lim;
    if (d > 0) return p + STEP > lim ? 0 : p + STEP;
    if (d < 0) return p < STEP ? lim : p - STEP;
    return p;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mdir = 0; mcnt = 0;
    mext = 0; mbrk = 0; mmode = 0; mpend = 0; mupd = 0;
  endtask

  task automatic model_edge();
    int hl, vl, d;
    bit t, upd;
    hl = (mmode ? 800 : 640) - 50;
    vl = (mmode ? 600 : 480) - 50;
    t = mcnt == TD - 1;
`ifdef KEY_MOVE_FRAME_SYNC_EN
    upd = (mpend || t) && frame_start;
    mpend = !upd && (mpend || t);
`else
    upd = t;
`endif
    mupd = upd;
    mx = wrap_step(mx, hl, !upd ? 0 : mdir == 1 ? 1 : mdir == 2 ? -1 : 0);
    my = wrap_step(my, vl, !upd ? 0 : mdir == 4 ? 1 : mdir == 8 ? -1 : 0);
    if (new_code) begin
      d = code_dir(key, mext);
      if (mbrk) begin
        if (d != 0 && d == mdir) mdir = 0;
        mext = 0; mbrk = 0;
      end else if (key == 8'hF0) mbrk = 1;
      else if (key == 8'hE0) mext = 1;
      else begin
        if (d != 0) mdir = d;
        mext = 0;
      end
    end
    mcnt = (mcnt + 1) % TD;
    mmode = mode;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("pos_x", pos_x, mx);
    check("pos_y", pos_y, my);
    check("dir", dir, mdir);
    check("tick", tick, mcnt == TD - 1);
  endtask

  task automatic send(input logic [7:0] k);
    key = k;
    new_code = 1;
    cyc();
    new_code = 0;
    key = 8'h00;
  endtask

  task automatic wait_upd(input int n);
    int seen = 0;
    for (int i = 0; i < 64 * n && seen < n; i++) begin
      cyc();
      seen += int'(mupd);
    end
    if (seen < n) check("upd_timeout", seen, n);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    check("rst_pos_x", pos_x, 0);
    check("rst_pos_y", pos_y, 0);
    check("rst_dir", dir, 0);
    check("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #2;
    frame_start = 1;
    do_reset();
    send(8'h23); check("dir_right", dir, 1);
    wait_upd(3); check("x_after3", pos_x, 3); check("y_after3", pos_y, 0);
    for (int i = 0; i < 700 && pos_x != 589; i++) wait_upd(1);
    check("x_589", pos_x, 589);
    wait_upd(1); check("x_590", pos_x, 590);
    wait_upd(1); check("x_wrap0", pos_x, 0);
    send(8'h1C); check("dir_left", dir, 2);
    wait_upd(1); check("x_left_m0", pos_x, 590);
    send(8'h23); wait_upd(1); check("x_back0", pos_x, 0);
    mode = 1;
    send(8'h1C); wait_upd(1); check("x_left_m1", pos_x, 750);
    for (int i = 0; i < 100 && pos_x != 700; i++) wait_upd(1);
    send(8'h1B);
    for (int i = 0; i < 600 && pos_y != 500; i++) wait_upd(1);
    send(8'hF0); send(8'h1B); check("dir_stop", dir, 0);
    check("x_700", pos_x, 700); check("y_500", pos_y, 500);
    mode = 0;
    cyc(); check("clamp_wait", pos_x, 700);
    cyc(); check("clamp_x", pos_x, 590); check("clamp_y", pos_y, 430);
    send(8'h1B); wait_upd(1); check("y_wrap0", pos_y, 0);
    send(8'hE0); send(8'h75); check("dir_up", dir, 8);
    wait_upd(1); check("y_wrap_up", pos_y, 430);
    send(8'hE0); send(8'hF0); send(8'h75); check("dir_ext_brk", dir, 0);
    wait_upd(10); check("frozen_x", pos_x, 590); check("frozen_y", pos_y, 430);
    send(8'h23); check("dir_hold", dir, 1);
    send(8'hF0); send(8'h1C); check("dir_other_brk", dir, 1);
    send(8'hF0); send(8'h23); check("dir_brk", dir, 0);
    send(8'h1D); send(8'h1B); check("dir_last_wins", dir, 4);
    for (int i = 0; i < 3000; i++) begin
      new_code = $urandom_range(3) == 0;
      key = $urandom_range(4) == 0 ? 8'($urandom) : codes[$urandom_range(9)];
      if ($urandom_range(63) == 0) mode = ~mode;
`ifdef KEY_MOVE_FRAME_SYNC_EN
      frame_start = $urandom_range(7) == 0;
`endif
      cyc();
    end
    new_code = 0; key = 0; frame_start = 1; mode = 0;
    send(8'h1B); wait_upd(2);
    do_reset();
`ifdef KEY_MOVE_FRAME_SYNC_EN
    frame_start = 0;
    send(8'h23);
    repeat (12) cyc();
    check("fs_hold", pos_x, 0);
    frame_start = 1; cyc(); frame_start = 0;
    check("fs_step", pos_x, 1);
    repeat (3) cyc();
    check("fs_once", pos_x, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_move_ctrl.md
# key_move_ctrl

Keyboard-driven movement controller for the VGA moving-block datapath. Decodes PS/2 make/break scancodes into a held direction, runs the movement prescaler, and drives the block's top-left position (`pos_x`, `pos_y`) with per-resolution wrap-around. Sits between the PS/2 receiver (`key`, `new_code`) and the pixel compositor, replacing free-running position logic with a reset-clean, frame-synchronisable scheduler.

## Interface
- `TICK_DIV`, 131072: clk cycles per movement tick; must be ≥ 2.
- `STEP`, 1: pixels moved per tick; must be ≥ 1 and < `BLK_W`, `BLK_H`.
- `BLK_W`, 50: block width in pixels.
- `BLK_H`, 50: block height in pixels.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `mode`  input  1  resolution: 0 = 640x480, 1 = 800x600.
- `key`  input  8  scancode byte; valid only while `new_code` = 1.
- `new_code`  input  1  one-cycle strobe: new byte on `key`.
- `frame_start`  input  1  one-cycle strobe at the start of vertical blanking (used only with `FRAME_SYNC_EN`).
- `pos_x`  output  11  block left edge, range 0..h_res-BLK_W.
- `pos_y`  output  11  block top edge, range 0..v_res-BLK_H.
- `dir`  output  4  held direction, one-hot: 0001 right, 0010 left, 0100 down, 1000 up; 0000 = stopped.
- `tick`  output  1  one-cycle movement tick from the prescaler.

## Operation
- Reset values: `pos_x` = 0, `pos_y` = 0, `dir` = 0000, `tick` = 0. Scan FSM is in IDLE, prescaler = 0, pending flag = 0.
- Scan FSM. It advances only on `new_code`:
  - IDLE: E0 -> EXT; F0 -> BRK; make code -> set `dir`, stay in IDLE; other bytes are ignored.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; extended make -> set `dir`, then IDLE; other bytes -> IDLE.
  - BRK / EXT_BRK: any byte -> IDLE. If the byte maps to the currently held direction in the same (plain/extended) class, `dir` is cleared to 0000. Otherwise `dir` is unchanged.
- Key map:
  - Plain codes: 23 right, 1C left, 1B down, 1D up.
  - Extended codes (E0 prefix): 74 right, 6B left, 72 down, 75 up.
- A new make code replaces the held direction; the last key pressed wins.
- Resolution: h_res/v_res are registered from `mode` every cycle (640/480 or 800/600).
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` = 1 in the cycle the count equals TICK_DIV-1.
- Move step, applied on an update event when `dir` is non-zero. All arithmetic is 12-bit, with no unsigned underflow:
  - Right: if `pos_x` + STEP > h_res-BLK_W then 0, else `pos_x` + STEP.
  - Left: if `pos_x` < STEP then h_res-BLK_W, else `pos_x` - STEP.
  - Down and up: same rule on `pos_y` with v_res-BLK_H.
- Mode clamp: if, after a resolution change, `pos_x` > h_res-BLK_W, it is forced to h_res-BLK_W on the next edge; `pos_y` likewise. The clamp has priority over a move in the same cycle.
- `new_code` and an update event in the same cycle: the move uses the old `dir`; the new `dir` applies from the next event.
- Reset asserted mid-operation returns every register to its reset value immediately.

## Timing
- `dir` changes on the edge that ends the `new_code` cycle, so it is visible 1 cycle later.
- Without `FRAME_SYNC_EN`, the update event is `tick`. Positions change on the edge that ends the `tick` cycle.
- With `FRAME_SYNC_EN`, see Configuration.
- Clamp latency: 2 cycles after `mode` changes (register h_res/v_res, then clamp).
- First `tick` after reset release: cycle TICK_DIV-1.

## Configuration
- `KEY_MOVE_FRAME_SYNC_EN` defined:
  - `tick` sets a single pending flag.
  - The update event is pending & `frame_start`; the flag then clears.
  - `tick` and `frame_start` in the same cycle produce an update.
  - Multiple ticks between frames give one step only.
  - Positions therefore never change mid-frame.
- Not defined: `frame_start` is ignored, there is no pending flag, and `tick` updates positions directly.

## Structure
- `key_move_pkg` holds:
  - scancode constants (E0, F0, the eight direction codes);
  - the `dir` one-hot localparams;
  - the resolution constants 640/480/800/600;
  - the scan FSM state enum (IDLE, EXT, BRK, EXT_BRK).
- One sub-module, `ps2_scan_fsm`: inputs `key`/`new_code`; outputs `dir` (it owns the held-direction register). The top level holds the prescaler, pending flag, resolution registers and position registers.

## Test plan
- Bench parameters: TICK_DIV = 4, STEP = 1, defaults otherwise.
- Reset, mode 0, send 23 -> `dir` = 0001 one cycle later; after 3 ticks `pos_x` = 3, `pos_y` = 0.
- Hold right with `pos_x` = 589 -> after 2 ticks, 590 then 0. Left from `pos_x` = 0 -> 590 in mode 0, 750 in mode 1.
- Send E0 75 -> `dir` = 1000 and `pos_y` wraps 0 -> 430. Then E0 F0 75 -> `dir` = 0000 and position is frozen for 10 ticks.
- Hold 23, send F0 1C -> `dir` stays 0001. Send F0 23 -> `dir` = 0000. Send 1D then 1B -> `dir` = 0100 (last wins).
- Mode 1, `pos_x` = 700, `pos_y` = 500, switch to mode 0 -> 590/430 two cycles later. Assert `rst` mid-move -> all outputs 0 at once.
- With `KEY_MOVE_FRAME_SYNC_EN`, hold right, let 3 ticks pass without `frame_start` -> `pos_x` unchanged. One `frame_start` pulse -> `pos_x` + 1 exactly once.
